// File: rtl/ifid_hold_if.sv
// ifid_hold_if: bundles the fetch, hazard and decode signals of the IF/ID hold
// controller. The master modport is the pipeline side. It drives fetch data, the stall
// and branch requests, and the decoder control bundle. The slave modport is the controller.
interface ifid_hold_if #(
  parameter int CTRL_W = 9,
  parameter int CNT_W  = 16
) ();
  logic              stall_i;
  logic              branch_taken_i;
  logic [31:0]       if_pc4_i;
  logic [31:0]       if_instr_i;
  logic [CTRL_W-1:0] id_ctrl_i;
  logic              pc_write_o;
  logic [31:0]       ifid_pc4_o;
  logic [31:0]       ifid_instr_o;
  logic              ifid_valid_o;
  logic [CTRL_W-1:0] idex_ctrl_o;
  logic              stall_err_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    output stall_i, branch_taken_i, if_pc4_i, if_instr_i, id_ctrl_i,
    input  pc_write_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o, idex_ctrl_o,
           stall_err_o, stall_cnt_o
  );

  modport slave (
    input  stall_i, branch_taken_i, if_pc4_i, if_instr_i, id_ctrl_i,
    output pc_write_o, ifid_pc4_o, ifid_instr_o, ifid_valid_o, idex_ctrl_o,
           stall_err_o, stall_cnt_o
  );
endinterface

// File: rtl/ifid_hold_ctrl.sv
// ifid_hold_ctrl: owns the IF/ID register and the ID/EX control register.
// A stall freezes IF/ID, gates the PC write and injects an ID/EX bubble.
// A taken branch (when not stalled) flushes IF/ID.
// A RUN/HOLD FSM measures consecutive stall cycles and drives a sticky watchdog error.
// Optional feature macro: STALL_CNT_EN enables a saturating stalled-cycle counter on
// stall_cnt_o. Without the macro, that port is tied to zero.
module ifid_hold_ctrl #(
  parameter int CTRL_W    = 9,
  parameter int MAX_STALL = 4,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  ifid_hold_if.slave bus
);

  typedef enum logic {RUN, HOLD} state_t;

  localparam logic [3:0] MAX_LEN = 4'(MAX_STALL);

  state_t            state_q, state_d;
  logic [3:0]        run_len_q, run_len_d;
  logic              err_q, err_d;
  logic [31:0]       pc4_q, pc4_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] idex_q, idex_d;

  // PC write is blocked while a stall is requested or reset is held
  assign bus.pc_write_o = rst_n & ~bus.stall_i;

  // Pipeline register next values: stall beats branch, branch beats normal fetch
  always_comb begin
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    idex_d  = '0;
    if (bus.stall_i) begin
      idex_d = '0;
    end else if (bus.branch_taken_i) begin
      pc4_d   = '0;
      instr_d = '0;
      valid_d = 1'b0;
      idex_d  = valid_q ? bus.id_ctrl_i : '0;
    end else begin
      pc4_d   = bus.if_pc4_i;
      instr_d = bus.if_instr_i;
      valid_d = 1'b1;
      idex_d  = valid_q ? bus.id_ctrl_i : '0;
    end
  end

  // Stall-run FSM and watchdog next state; run length saturates at MAX_STALL
  always_comb begin
    state_d   = state_q;
    run_len_d = run_len_q;
    case (state_q)
      RUN: begin
        if (bus.stall_i) begin
          state_d   = HOLD;
          run_len_d = 4'd1;
        end
      end
      HOLD: begin
        if (bus.stall_i) begin
          state_d   = HOLD;
          run_len_d = (run_len_q >= MAX_LEN) ? MAX_LEN : run_len_q + 4'd1;
        end else begin
          state_d   = RUN;
          run_len_d = 4'd0;
        end
      end
      default: begin
        state_d   = RUN;
        run_len_d = 4'd0;
      end
    endcase
    err_d = err_q | (run_len_d == MAX_LEN);
  end

  // State registers, all cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      run_len_q <= 4'd0;
      err_q     <= 1'b0;
      pc4_q     <= '0;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      idex_q    <= '0;
    end else begin
      state_q   <= state_d;
      run_len_q <= run_len_d;
      err_q     <= err_d;
      pc4_q     <= pc4_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      idex_q    <= idex_d;
    end
  end

  assign bus.ifid_pc4_o   = pc4_q;
  assign bus.ifid_instr_o = instr_q;
  assign bus.ifid_valid_o = valid_q;
  assign bus.idex_ctrl_o  = idex_q;
  assign bus.stall_err_o  = err_q;

`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stalled-cycle counter next value, holding at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (bus.stall_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.stall_cnt_o = cnt_q;
`else
  assign bus.stall_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ifid_hold_ctrl.sv
// tb_ifid_hold_ctrl: directed test of ifid_hold_ctrl with CTRL_W=9, MAX_STALL=4, CNT_W=3.
module tb_ifid_hold_ctrl;
  localparam int CTRL_W    = 9;
  localparam int MAX_STALL = 4;
  localparam int CNT_W     = 3;

`ifdef STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  ifid_hold_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

  ifid_hold_ctrl #(
    .CTRL_W(CTRL_W), .MAX_STALL(MAX_STALL), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic br, input logic [31:0] pc4,
                       input logic [31:0] instr, input logic [CTRL_W-1:0] ctrl);
    bus.stall_i        = st;
    bus.branch_taken_i = br;
    bus.if_pc4_i       = pc4;
    bus.if_instr_i     = instr;
    bus.id_ctrl_i      = ctrl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] pc4, input logic [31:0] instr,
                          input logic valid, input logic [CTRL_W-1:0] idex);
    chk({tag, "_pc4"},   bus.ifid_pc4_o,   pc4);
    chk({tag, "_instr"}, bus.ifid_instr_o, instr);
    chk({tag, "_valid"}, 32'(bus.ifid_valid_o), 32'(valid));
    chk({tag, "_idex"},  32'(bus.idex_ctrl_o),  32'(idex));
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 9'h0);

    // Reset state
    #1;
    chk_ifid("rst", 32'h0, 32'h0, 1'b0, 9'h0);
    chk("rst_err",   32'(bus.stall_err_o), 32'h0);
    chk("rst_cnt",   32'(bus.stall_cnt_o), 32'h0);
    chk("rst_pcw",   32'(bus.pc_write_o),  32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Normal fetch 0x11; IF/ID was empty so ID/EX gets a bubble
    drive(1'b0, 1'b0, 32'h4, 32'h11, 9'h0AA);
    #1 chk("f1_pcw", 32'(bus.pc_write_o), 32'h1);
    tick();
    chk_ifid("f1", 32'h4, 32'h11, 1'b1, 9'h0);
    $display("step fetch 0x11 done");

    // Fetch 0x22; 0x11's control bundle enters ID/EX
    drive(1'b0, 1'b0, 32'h8, 32'h22, 9'h1A5);
    tick();
    chk_ifid("f2", 32'h8, 32'h22, 1'b1, 9'h1A5);
    $display("step fetch 0x22 done");

    // Single stall while IF/ID=0x22: hold, bubble, PC gated
    drive(1'b1, 1'b0, 32'hC, 32'h33, 9'h0F0);
    #1 chk("s1_pcw", 32'(bus.pc_write_o), 32'h0);
    tick();
    chk_ifid("s1", 32'h8, 32'h22, 1'b1, 9'h0);
    chk("s1_err", 32'(bus.stall_err_o), 32'h0);
    $display("step single stall done");

    // Stall released: 0x22 issues, 0x33 captured
    drive(1'b0, 1'b0, 32'hC, 32'h33, 9'h0F0);
    #1 chk("f3_pcw", 32'(bus.pc_write_o), 32'h1);
    tick();
    chk_ifid("f3", 32'hC, 32'h33, 1'b1, 9'h0F0);
    $display("step fetch 0x33 done");

    // Stall with branch for two cycles: stall wins, two bubbles
    drive(1'b1, 1'b1, 32'h10, 32'h44, 9'h155);
    tick();
    chk_ifid("sb1", 32'hC, 32'h33, 1'b1, 9'h0);
    tick();
    chk_ifid("sb2", 32'hC, 32'h33, 1'b1, 9'h0);
    chk("sb2_err", 32'(bus.stall_err_o), 32'h0);
    $display("step stall+branch x2 done");

    // Branch alone: flush IF/ID, 0x33's bundle issues
    drive(1'b0, 1'b1, 32'h10, 32'h44, 9'h155);
    tick();
    chk_ifid("br", 32'h0, 32'h0, 1'b0, 9'h155);
    $display("step branch flush done");

    // Following cycle: flushed slot produces a bubble
    drive(1'b0, 1'b0, 32'h14, 32'h55, 9'h1FF);
    tick();
    chk_ifid("afb", 32'h14, 32'h55, 1'b1, 9'h0);
    $display("step post-flush fetch done");

    // Watchdog: four consecutive stalls, error rises on the fourth
    drive(1'b1, 1'b0, 32'h18, 32'h66, 9'h0C3);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("wd%0d_err", i), 32'(bus.stall_err_o), (i == 4) ? 32'h1 : 32'h0);
    end
    chk_ifid("wd", 32'h14, 32'h55, 1'b1, 9'h0);
    chk("wd_cnt", 32'(bus.stall_cnt_o), CNT_ON ? 32'h7 : 32'h0);
    $display("step watchdog 4 stalls done");

    // Stall dropped: error sticky, held instruction issues
    drive(1'b0, 1'b0, 32'h18, 32'h66, 9'h0C3);
    tick();
    chk("wdr_err", 32'(bus.stall_err_o), 32'h1);
    chk_ifid("wdr", 32'h18, 32'h66, 1'b1, 9'h0C3);
    $display("step stall release done");

    // Enter HOLD, then async reset mid-cycle
    drive(1'b1, 1'b0, 32'h1C, 32'h70, 9'h011);
    tick();
    tick();
    chk("hold_cnt", 32'(bus.stall_cnt_o), CNT_ON ? 32'h7 : 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk_ifid("ar", 32'h0, 32'h0, 1'b0, 9'h0);
    chk("ar_err", 32'(bus.stall_err_o), 32'h0);
    chk("ar_cnt", 32'(bus.stall_cnt_o), 32'h0);
    chk("ar_pcw", 32'(bus.pc_write_o),  32'h0);
    $display("step async reset mid-HOLD done");

    // Release: first edge loads fetch data normally
    tick();
    drive(1'b0, 1'b0, 32'h20, 32'h77, 9'h100);
    rst_n = 1'b1;
    #1 chk("rr_pcw", 32'(bus.pc_write_o), 32'h1);
    tick();
    chk_ifid("rr", 32'h20, 32'h77, 1'b1, 9'h0);
    $display("step fetch after reset done");

    // Nine stalls: counter saturates at 7 when enabled
    drive(1'b1, 1'b0, 32'h24, 32'h88, 9'h022);
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 3 || i == 7 || i == 9)
        chk($sformatf("cnt%0d", i), 32'(bus.stall_cnt_o),
            CNT_ON ? ((i > 7) ? 32'h7 : 32'(i)) : 32'h0);
    end
    chk("cnt_err", 32'(bus.stall_err_o), 32'h1);
    chk_ifid("cnt", 32'h20, 32'h77, 1'b1, 9'h0);
    $display("step nine stalls done");

    drive(1'b0, 1'b0, 32'h0, 32'h0, 9'h0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ifid_hold_ctrl.md
# ifid_hold_ctrl

Consumer of the pipeline's stall request: owns the IF/ID pipeline register and the ID/EX control-field register. On stall it gates the PC write, freezes IF/ID and injects a bubble into ID/EX. On a taken branch it flushes IF/ID. It also runs a consecutive-stall watchdog and an optional stall performance counter. It sits between instruction fetch, the hazard detection unit and the ID/EX register.

## Interface
Parameters:
- CTRL_W, 9: width of the decoded control bundle passed to ID/EX.
- MAX_STALL, 4: consecutive stall cycles that set the watchdog error (legal range 2..15).
- CNT_W, 16: stall performance counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, reset asynchronous and active-low.
- stall_i  in  1  stall request from hazard detection, valid for the current cycle.
- branch_taken_i  in  1  branch resolved taken in ID this cycle.
- if_pc4_i  in  32  PC+4 from fetch.
- if_instr_i  in  32  fetched instruction.
- id_ctrl_i  in  CTRL_W  decoder control bundle for the instruction in ID.
- pc_write_o  out  1  PC register write enable.
- ifid_pc4_o  out  32  IF/ID PC+4.
- ifid_instr_o  out  32  IF/ID instruction.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- idex_ctrl_o  out  CTRL_W  ID/EX control bundle; all-zero means bubble.
- stall_err_o  out  1  sticky watchdog error.
- stall_cnt_o  out  CNT_W  total stalled cycles (see Configuration).

## Operation
- pc_write_o = rst_n & ~stall_i (combinational). This is the only combinational output.
- Per-edge priority (highest first):
  - stall_i=1: IF/ID holds all fields, including valid. idex_ctrl_o <= 0. Any branch_taken_i is ignored, because branch operands are not ready.
  - branch_taken_i=1: IF/ID flush. ifid_instr_o <= 0 (NOP), ifid_pc4_o <= 0, ifid_valid_o <= 0. idex_ctrl_o <= ifid_valid_o ? id_ctrl_i : 0.
  - otherwise: IF/ID <= {if_pc4_i, if_instr_i}, ifid_valid_o <= 1. idex_ctrl_o <= ifid_valid_o ? id_ctrl_i : 0.
- State machine, 2 states:
  - RUN: stall_i=1 -> HOLD, with run_len <= 1.
  - HOLD: stall_i=1 -> HOLD, with run_len <= run_len+1, saturating at MAX_STALL. stall_i=0 -> RUN, with run_len <= 0.
- Watchdog: stall_err_o <= 1 on the edge where run_len reaches MAX_STALL. It stays set until reset.
- stall_i=1 for exactly 1 or 2 consecutive cycles is normal (load-use, then load-use feeding a branch). It never sets the error while MAX_STALL >= 3.

## Timing
- Reset (rst_n low, asynchronous) clears:
  - all IF/ID fields to 0, ifid_valid_o=0
  - idex_ctrl_o=0
  - state RUN, run_len=0
  - stall_err_o=0, stall_cnt_o=0
  - pc_write_o=0 while held
- Reset mid-stall discards the held instruction. The first edge after release loads fetch data as a normal cycle.
- Latency: fetch data appears on IF/ID outputs 1 cycle after capture. A control bundle reaches idex_ctrl_o 1 cycle after the instruction sits in IF/ID.
- A stall asserted in cycle N produces a bubble in idex_ctrl_o at N+1. The held instruction re-enters ID at N+1 and issues at the first edge with stall_i=0.
- stall_i and branch_taken_i together: the stall wins. The branch is re-evaluated next cycle.
- The watchdog counter saturates; it never wraps.

## Configuration
- STALL_CNT_EN defined:
  - A CNT_W-bit counter increments on every edge with stall_i=1.
  - It saturates at all-ones and is cleared only by reset.
- STALL_CNT_EN undefined:
  - No counter flops.
  - stall_cnt_o is tied to 0; the port stays present.

## Test plan
- Reset, then 3 normal fetches (instr 0x11, 0x22, 0x33) -> IF/ID follows with 1-cycle lag. ifid_valid_o=1 from the 1st post-reset edge. idex_ctrl_o=id_ctrl_i one cycle later. pc_write_o=1 throughout.
- Single stall while IF/ID=0x22 -> pc_write_o=0 that cycle, IF/ID still 0x22 next cycle, idex_ctrl_o=0 for exactly 1 cycle, stall_err_o=0.
- stall_i=1 for 2 cycles together with branch_taken_i=1, then branch_taken_i=1 alone -> 2 bubbles, then flush: ifid_instr_o=0, ifid_valid_o=0. The following idex_ctrl_o=0.
- stall_i held 4 cycles with MAX_STALL=4 -> stall_err_o rises on the 4th stall edge, stays 1 after stall_i drops, clears only on rst_n low.
- With STALL_CNT_EN and CNT_W=3: apply 9 stall cycles -> stall_cnt_o=7 (saturated). Without the macro -> stall_cnt_o=0.
- Assert rst_n low asynchronously mid-HOLD -> all outputs clear immediately without a clock edge. After release, normal fetch resumes.
